// File: rtl/trace_pkg.sv
// Shared types for trace packages sent to the debug monitor.
package trace_pkg;

  localparam int unsigned TRACE_W        = 256;
  localparam int unsigned TRACE_PC_LSB   = 160;
  localparam int unsigned TRACE_VIRT_BIT = 255;
  localparam int unsigned SEQ_W          = 8;

  // 256-bit package, MSB first
  typedef struct packed {
    logic        virt;
    logic [12:0] rsvd;
    logic [1:0]  prv;
    logic [7:0]  seq;
    logic        trap;
    logic        mem_en;
    logic        rd_we;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic [63:0] mem_addr;
    logic [31:0] inst;
    logic [63:0] wdata;
  } trace_pkg_t;

  // One lane of retire information from the commit stage
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rd_we;
    logic [63:0] wdata;
    logic        mem_en;
    logic [63:0] mem_addr;
    logic        trap;
    logic [1:0]  prv;
    logic        virt;
  } rt_info_t;

  // Format one retire into a package; mem_addr is zeroed for non-memory ops
  function automatic trace_pkg_t make_trace(input rt_info_t ri, input logic [SEQ_W-1:0] seq);
    trace_pkg_t t;
    t          = '0;
    t.wdata    = ri.wdata;
    t.inst     = ri.inst;
    t.mem_addr = ri.mem_en ? ri.mem_addr : 64'd0;
    t.pc       = ri.pc;
    t.rd       = ri.rd;
    t.rd_we    = ri.rd_we;
    t.mem_en   = ri.mem_en;
    t.trap     = ri.trap;
    t.seq      = seq;
    t.prv      = ri.prv;
    t.virt     = ri.virt;
    return t;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Package FIFO: two write ports (push count 0..2), one read port, wrap-bit pointers.
module trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 256
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [1:0]             i_push_n,
  input  logic [W-1:0]           i_wdata0,
  input  logic [W-1:0]           i_wdata1,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [$clog2(DEPTH):0] o_free,
  output logic                   o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] w_wr_idx0;
  logic [AW-1:0] w_wr_idx1;

  assign w_wr_idx0 = r_wr_ptr[AW-1:0];
  assign w_wr_idx1 = AW'(r_wr_ptr + PW'(1));
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_free    = PW'(DEPTH) - o_count;
  assign o_empty   = (o_count == '0);
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; caller never pops empty nor pushes past free
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_push_n);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop);
    end
  end

  // Storage write, older entry on port 0
  always_ff @(posedge clk) begin
    if (i_push_n != 2'd0) r_mem[w_wr_idx0] <= i_wdata0;
    if (i_push_n == 2'd2) r_mem[w_wr_idx1] <= i_wdata1;
  end

endmodule

// File: rtl/trace_pkg_gen.sv
// Packs up to two retires per cycle into trace packages; FIFO-buffered, one package out per cycle.
module trace_pkg_gen
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_trace_en,
  input  logic                i_ovf_clr,
  input  logic [1:0]          i_rt_valid,
  input  logic [1:0][63:0]    i_rt_pc,
  input  logic [1:0][31:0]    i_rt_inst,
  input  logic [1:0][4:0]     i_rt_rd,
  input  logic [1:0]          i_rt_rd_we,
  input  logic [1:0][63:0]    i_rt_wdata,
  input  logic [1:0]          i_rt_mem_en,
  input  logic [1:0][63:0]    i_rt_mem_addr,
  input  logic [1:0]          i_rt_trap,
  input  logic [1:0][1:0]     i_rt_prv,
  input  logic [1:0]          i_rt_virt,
  output logic                o_pkg_valid,
  output logic [TRACE_W-1:0]  o_pkg,
  output logic                o_overflow,
  output logic [CNT_W-1:0]    o_drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  rt_info_t          w_info [2];
  logic [1:0]        w_acc;
  logic [1:0]        w_n_acc;
  trace_pkg_t        w_pkt0;
  trace_pkg_t        w_pkt1;
  trace_pkg_t        w_first;
  logic [TRACE_W-1:0] w_head;
  logic [TRACE_W-1:0] w_wdata0;
  logic [TRACE_W-1:0] w_wdata1;
  logic [PW-1:0]     w_count;
  logic [PW-1:0]     w_free;
  logic [PW-1:0]     w_free_after;
  logic              w_empty;
  logic              w_pop;
  logic              w_bypass;
  logic [1:0]        w_cand_n;
  logic [1:0]        w_push_n;
  logic [1:0]        w_drop_n;
  logic [CNT_W:0]    w_cnt_sum;

  logic [SEQ_W-1:0]  r_seq;
  logic              r_pkg_valid;
  trace_pkg_t        r_pkg;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_cnt;

  // Gather per-lane retire fields
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_info[i].pc       = i_rt_pc[i];
      w_info[i].inst     = i_rt_inst[i];
      w_info[i].rd       = i_rt_rd[i];
      w_info[i].rd_we    = i_rt_rd_we[i];
      w_info[i].wdata    = i_rt_wdata[i];
      w_info[i].mem_en   = i_rt_mem_en[i];
      w_info[i].mem_addr = i_rt_mem_addr[i];
      w_info[i].trap     = i_rt_trap[i];
      w_info[i].prv      = i_rt_prv[i];
      w_info[i].virt     = i_rt_virt[i];
    end
  end

  // Lane 1 takes seq+1 only when lane 0 is also accepted
  assign w_acc    = i_rt_valid & {2{i_trace_en}};
  assign w_n_acc  = 2'(w_acc[0]) + 2'(w_acc[1]);
  assign w_pkt0   = make_trace(w_info[0], r_seq);
  assign w_pkt1   = make_trace(w_info[1], r_seq + SEQ_W'(w_acc[0]));
  assign w_first  = w_acc[0] ? w_pkt0 : w_pkt1;
  assign w_pop    = (w_count != '0);
  assign w_bypass = w_empty && (w_n_acc != 2'd0);

  // Push selection: bypass consumes the oldest lane; youngest lanes drop when space runs out
  always_comb begin
    w_wdata0     = w_first;
    w_wdata1     = w_pkt1;
    w_cand_n     = w_n_acc;
    w_free_after = w_free + PW'(w_pop);
    if (w_bypass) begin
      w_wdata0 = w_pkt1;
      w_cand_n = w_n_acc - 2'd1;
    end
    if (PW'(w_cand_n) <= w_free_after) w_push_n = w_cand_n;
    else                               w_push_n = w_free_after[1:0];
    w_drop_n = w_cand_n - w_push_n;
  end

  assign w_cnt_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_n);

  trace_fifo #(.DEPTH(DEPTH), .W(TRACE_W)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .i_push_n (w_push_n),
    .i_wdata0 (w_wdata0),
    .i_wdata1 (w_wdata1),
    .i_pop    (w_pop),
    .o_rdata  (w_head),
    .o_count  (w_count),
    .o_free   (w_free),
    .o_empty  (w_empty)
  );

  // Output register and sequence counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seq       <= '0;
      r_pkg_valid <= 1'b0;
      r_pkg       <= '0;
    end else begin
      r_seq <= r_seq + SEQ_W'(w_n_acc);
      if (w_pop) begin
        r_pkg_valid <= 1'b1;
        r_pkg       <= trace_pkg_t'(w_head);
      end else if (w_bypass) begin
        r_pkg_valid <= 1'b1;
        r_pkg       <= w_first;
      end else begin
        r_pkg_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow and saturating drop counter; clear wins over a same-cycle drop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop_n != 2'd0) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end
  end

  assign o_pkg_valid = r_pkg_valid;
  assign o_pkg       = r_pkg;
  assign o_overflow  = r_overflow;
  assign o_drop_cnt  = r_drop_cnt;

endmodule
